pc_ctrl: RTL and testbench

Parametrised program-counter unit for the instruction-fetch stage, and the successor to the current fixed 9-bit fetch PC. Adds PC-relative signed branches, call/return through an internal return-address stack (RAS), and sticky stack-error flags on top of absolute jump, halt and increment. The PC output drives the instruction-memory address.

---
 rtl/pc_ctrl.sv | 123 ++++++++++++
 tb/tb_pc_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Fetch-stage program counter with signed relative branch, call/return through a circular RAS and sticky stack-error flags.
// Optional macro PC_CTRL_BRANCH_CNT_EN enables the saturating taken-redirect counter on Branch_Cnt.
module pc_ctrl #(
  parameter int PC_W      = 9,
  parameter int OFF_W     = 9,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic                           Halt,
  input  logic                           Abs_Jump,
  input  logic [PC_W-1:0]                Target,
  input  logic                           Rel_Branch,
  input  logic [OFF_W-1:0]               Rel_Offset,
  input  logic                           Call,
  input  logic                           Ret,
  output logic [PC_W-1:0]                PC,
  output logic [$clog2(RAS_DEPTH):0]     Ras_Count,
  output logic                           Ras_Overflow,
  output logic                           Ras_Underflow,
  output logic [15:0]                    Branch_Cnt
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  function automatic logic signed [PC_W-1:0] sext(input logic [OFF_W-1:0] off);
    logic signed [PC_W-1:0] r;
    for (int i = 0; i < PC_W; i++)
      r[i] = (i < OFF_W) ? off[i] : off[OFF_W-1];
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PC_W-1:0]  pc_q, pc_nxt, pc_inc;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [PTR_W-1:0] top_q, top_nxt;
  logic             ovf_q, ovf_nxt, unf_q, unf_nxt, push;
  logic signed [PC_W-1:0] off_ext;
  logic [PC_W-1:0]  ras [RAS_DEPTH];

  assign pc_inc  = pc_q + 1'b1;
  assign off_ext = sext(Rel_Offset);

  // Arbitration: Halt > Ret > Call > Abs_Jump > Rel_Branch > increment
  always_comb begin
    pc_nxt  = pc_inc;
    cnt_nxt = cnt_q;
    top_nxt = top_q;
    ovf_nxt = ovf_q;
    unf_nxt = unf_q;
    push    = 1'b0;
    if (Halt) begin
      pc_nxt = pc_q;
    end else if (Ret) begin
      if (cnt_q != '0) begin
        pc_nxt  = ras[top_q];
        cnt_nxt = cnt_q - 1'b1;
        top_nxt = top_q - 1'b1;
      end else begin
        unf_nxt = 1'b1;
      end
    end else if (Call) begin
      push    = 1'b1;
      pc_nxt  = Target;
      top_nxt = top_q + 1'b1;
      if (cnt_q == FULL) ovf_nxt = 1'b1;
      else               cnt_nxt = cnt_q + 1'b1;
    end else if (Abs_Jump) begin
      pc_nxt = Target;
    end else if (Rel_Branch) begin
      pc_nxt = pc_q + off_ext;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc_q  <= PC_W'(RESET_PC);
      cnt_q <= '0;
      top_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
      top_q <= top_nxt;
      ovf_q <= ovf_nxt;
      unf_q <= unf_nxt;
    end
  end

  // Stack storage carries no reset; when full, top+1 lands on the oldest entry
  always_ff @(posedge CLK) begin
    if (Reset && push) ras[top_nxt] <= pc_inc;
  end

`ifdef PC_CTRL_BRANCH_CNT_EN
  logic [15:0] bcnt_q;
  logic        taken;

  assign taken = !Halt && ((Ret && cnt_q != '0) || Call || Abs_Jump || Rel_Branch);

  always_ff @(posedge CLK) begin
    if (!Reset)     bcnt_q <= '0;
    else if (taken) bcnt_q <= sat_inc(bcnt_q);
  end

  assign Branch_Cnt = bcnt_q;
`else
  assign Branch_Cnt = '0;
`endif

  assign PC            = pc_q;
  assign Ras_Count     = cnt_q;
  assign Ras_Overflow  = ovf_q;
  assign Ras_Underflow = unf_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl at default parameters (PC_W=9, RAS_DEPTH=4).
module tb_pc_ctrl;

  logic       CLK = 1'b0;
  logic       Reset, Halt, Abs_Jump, Rel_Branch, Call, Ret;
  logic [8:0] Target, Rel_Offset, PC;
  logic [2:0] Ras_Count;
  logic       Ras_Overflow, Ras_Underflow;
  logic [15:0] Branch_Cnt;

  int n_cmp = 0;
  int n_err = 0;

  pc_ctrl dut (
    .CLK(CLK), .Reset(Reset), .Halt(Halt), .Abs_Jump(Abs_Jump), .Target(Target),
    .Rel_Branch(Rel_Branch), .Rel_Offset(Rel_Offset), .Call(Call), .Ret(Ret),
    .PC(PC), .Ras_Count(Ras_Count), .Ras_Overflow(Ras_Overflow),
    .Ras_Underflow(Ras_Underflow), .Branch_Cnt(Branch_Cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Halt = 0; Abs_Jump = 0; Rel_Branch = 0; Call = 0; Ret = 0;
    Target = '0; Rel_Offset = '0;
  endtask

  // advance one edge, then settle before sampling and re-driving
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_call(input logic [8:0] t);
    idle(); Call = 1; Target = t; tick();
  endtask

  task automatic do_ret();
    idle(); Ret = 1; tick();
  endtask

  task automatic do_jump(input logic [8:0] t);
    idle(); Abs_Jump = 1; Target = t; tick();
  endtask

  logic [15:0] bc_exp;

  initial begin
    // 1: reset, then free-running increment
    idle(); Reset = 0;
    tick(); tick();
    chk("rst_pc", PC, 0);
    chk("rst_cnt", Ras_Count, 0);
    chk("rst_ovf", Ras_Overflow, 0);
    chk("rst_unf", Ras_Underflow, 0);
    chk("rst_bcnt", Branch_Cnt, 0);
    Reset = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("inc_%0d", i), PC, i);
    end
    chk("inc_cnt", Ras_Count, 0);
    chk("inc_flags", {Ras_Overflow, Ras_Underflow}, 0);

    // 2: relative branches and wrap
    idle(); Rel_Branch = 1; Rel_Offset = 9'd3; tick();
    chk("rel_fwd", PC, 8);
    Rel_Offset = 9'h1FC; tick();
    chk("rel_back", PC, 4);
    Rel_Offset = 9'h1F8; tick();
    chk("rel_wrap_neg", PC, 9'h1FC);
    do_jump(9'h1FF);
    chk("jmp_top", PC, 9'h1FF);
    idle(); tick();
    chk("inc_wrap", PC, 0);

    // 3: call / return / underflow
    do_jump(10);
    do_call(100);
    chk("call_pc", PC, 100);
    chk("call_cnt", Ras_Count, 1);
    idle(); tick(); tick();
    chk("pc_102", PC, 102);
    do_ret();
    chk("ret_pc", PC, 11);
    chk("ret_cnt", Ras_Count, 0);
    do_ret();
    chk("unf_pc", PC, 12);
    chk("unf_flag", Ras_Underflow, 1);
    chk("unf_cnt", Ras_Count, 0);
    idle(); tick(); tick(); tick();
    chk("unf_sticky", Ras_Underflow, 1);
    chk("unf_sticky_pc", PC, 15);

    // 4: overflow with 5 nested calls
    idle(); Reset = 0; tick(); Reset = 1;
    chk("rst2_unf", Ras_Underflow, 0);
    do_call(20); do_call(40); do_call(60); do_call(80);
    chk("full_cnt", Ras_Count, 4);
    chk("full_no_ovf", Ras_Overflow, 0);
    do_call(100);
    chk("ovf_pc", PC, 100);
    chk("ovf_cnt", Ras_Count, 4);
    chk("ovf_flag", Ras_Overflow, 1);
    do_ret(); chk("pop_81", PC, 81);
    do_ret(); chk("pop_61", PC, 61);
    do_ret(); chk("pop_41", PC, 41);
    do_ret(); chk("pop_21", PC, 21);
    chk("pop_cnt", Ras_Count, 0);
    chk("pop_no_unf", Ras_Underflow, 0);
    do_ret();
    chk("pop5_unf", Ras_Underflow, 1);
    chk("pop5_pc", PC, 22);

    // 5: priority
    do_jump(50);
    do_call(200);
    chk("pri_call_cnt", Ras_Count, 1);
    idle(); Halt = 1; Call = 1; Abs_Jump = 1; Target = 300; tick();
    chk("pri_halt_pc", PC, 200);
    chk("pri_halt_cnt", Ras_Count, 1);
    idle(); Ret = 1; Call = 1; Target = 300; tick();
    chk("pri_ret_pc", PC, 51);
    chk("pri_ret_cnt", Ras_Count, 0);
    idle(); Call = 1; Abs_Jump = 1; Target = 120; tick();
    chk("pri_call_pc", PC, 120);
    chk("pri_call_push", Ras_Count, 1);
    idle(); Abs_Jump = 1; Rel_Branch = 1; Target = 7; Rel_Offset = 5; tick();
    chk("pri_abs_pc", PC, 7);
    do_ret();
    chk("pri_ret_52", PC, 52);

    // 6: mid-operation reset and branch counter
    for (int i = 0; i < 5; i++) do_call(30);
    do_ret();
    chk("pre_rst_cnt", Ras_Count, 3);
    chk("pre_rst_flags", {Ras_Overflow, Ras_Underflow}, 2'b11);
    idle(); Reset = 0; Call = 1; Target = 77; tick(); Reset = 1;
    chk("mid_rst_pc", PC, 0);
    chk("mid_rst_cnt", Ras_Count, 0);
    chk("mid_rst_flags", {Ras_Overflow, Ras_Underflow}, 0);
    chk("mid_rst_bcnt", Branch_Cnt, 0);
    do_ret();
    chk("post_rst_unf", Ras_Underflow, 1);
    chk("post_rst_pc", PC, 1);
    do_jump(10); do_jump(20); do_jump(30);
    idle(); Halt = 1; tick();
    chk("halt_pc", PC, 30);
`ifdef PC_CTRL_BRANCH_CNT_EN
    bc_exp = 16'd3;
`else
    bc_exp = 16'd0;
`endif
    chk("bcnt", Branch_Cnt, bc_exp);
    idle(); tick();
    chk("bcnt_hold", Branch_Cnt, bc_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
